// File: rtl/riscv_pkg.sv
// Shared RV32I encodings used by the writeback stage and its load formatter.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // Writeback result source select.
  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10,
    RES_RSVD = 2'b11
  } result_src_e;

  // Load width/sign encodings carried in funct3.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_formatter.sv
// Extracts and sign/zero-extends load data from an aligned memory word
// and flags misaligned half/word accesses. Purely combinational.
module load_formatter
  import riscv_pkg::*;
(
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr,
  input  logic [XLEN-1:0] i_word,
  output logic [XLEN-1:0] o_data,
  output logic            o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Byte lane select by the low address bits.
  always_comb begin
    w_byte = i_word[7:0];
    case (i_addr)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
  end

  assign w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];

  // Width/sign formatting; undefined funct3 yields zero and no misalign.
  always_comb begin
    o_data     = '0;
    o_misalign = 1'b0;
    case (i_funct3)
      F3_LB:  o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LBU: o_data = {{(XLEN-8){1'b0}}, w_byte};
      F3_LH: begin
        o_data     = {{(XLEN-16){w_half[15]}}, w_half};
        o_misalign = i_addr[0];
      end
      F3_LHU: begin
        o_data     = {{(XLEN-16){1'b0}}, w_half};
        o_misalign = i_addr[0];
      end
      F3_LW: begin
        o_data     = i_word;
        o_misalign = (i_addr != 2'b00);
      end
      default: begin
        o_data     = '0;
        o_misalign = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback stage. Drives the register file
// write port and a forwarding tap; a done bit suppresses repeat writes
// while the stage is held by STALL.
// Optional: define WB_INSTRET_EN to add a 64-bit retired-instruction counter.
module wb_stage #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC4 = 32'h0000_0004
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            STALL,
  input  logic            FLUSH,
  input  logic            MEM_Valid,
  input  logic            MEM_RegWrite,
  input  logic [4:0]      MEM_Rd,
  input  logic [1:0]      MEM_ResultSrc,
  input  logic [2:0]      MEM_Funct3,
  input  logic [XLEN-1:0] MEM_ALUResult,
  input  logic [XLEN-1:0] MEM_ReadData,
  input  logic [XLEN-1:0] MEM_PCPlus4,
  output logic            WE3,
  output logic [4:0]      A3,
  output logic [XLEN-1:0] WD3,
  output logic            WB_Valid,
  output logic            WB_FwdEn,
  output logic            MisalignErr
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]     Instret
`endif
);

  import riscv_pkg::*;

  logic            r_valid;
  logic            r_regwrite;
  logic [4:0]      r_rd;
  logic [1:0]      r_resultsrc;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_aluresult;
  logic [XLEN-1:0] r_readdata;
  logic [XLEN-1:0] r_pcplus4;
  logic            r_done;

  logic [XLEN-1:0] w_load_data;
  logic            w_load_misalign;
  logic            w_misalign;
  logic            w_fwd_en;
  logic            w_we3;
  logic [XLEN-1:0] w_result;

  load_formatter u_load_formatter (
    .i_funct3   (r_funct3),
    .i_addr     (r_aluresult[1:0]),
    .i_word     (r_readdata),
    .o_data     (w_load_data),
    .o_misalign (w_load_misalign)
  );

  // Pipeline register: FLUSH bubbles, STALL holds (marking the write done), else capture.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_valid     <= 1'b0;
      r_regwrite  <= 1'b0;
      r_rd        <= 5'd0;
      r_resultsrc <= 2'b00;
      r_funct3    <= 3'b000;
      r_aluresult <= '0;
      r_readdata  <= '0;
      r_pcplus4   <= RESET_PC4;
      r_done      <= 1'b0;
    end else if (FLUSH) begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else if (STALL) begin
      r_done <= r_done | w_we3;
    end else begin
      r_valid     <= MEM_Valid;
      r_regwrite  <= MEM_RegWrite;
      r_rd        <= MEM_Rd;
      r_resultsrc <= MEM_ResultSrc;
      r_funct3    <= MEM_Funct3;
      r_aluresult <= MEM_ALUResult;
      r_readdata  <= MEM_ReadData;
      r_pcplus4   <= MEM_PCPlus4;
      r_done      <= 1'b0;
    end
  end

  // Writeback value select.
  always_comb begin
    w_result = '0;
    case (r_resultsrc)
      RES_ALU:  w_result = r_aluresult;
      RES_LOAD: w_result = w_load_data;
      RES_PC4:  w_result = r_pcplus4;
      default:  w_result = '0;
    endcase
  end

  assign w_misalign = r_valid & (r_resultsrc == RES_LOAD) & w_load_misalign;
  assign w_fwd_en   = r_valid & r_regwrite & (r_rd != 5'd0) & ~w_misalign;
  assign w_we3      = w_fwd_en & ~r_done;

  assign WE3         = w_we3;
  assign A3          = r_rd;
  assign WD3         = w_result;
  assign WB_Valid    = r_valid;
  assign WB_FwdEn    = w_fwd_en;
  assign MisalignErr = w_misalign;

`ifdef WB_INSTRET_EN
  logic [63:0] r_instret;
  logic        r_retire_done;
  logic        w_retire;

  assign w_retire = r_valid & ~r_retire_done & ~FLUSH & ~w_misalign;

  // Count each instruction once on retirement, independent of whether it writes rd.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_instret     <= 64'd0;
      r_retire_done <= 1'b0;
    end else begin
      if (w_retire) r_instret <= r_instret + 64'd1;
      if (FLUSH)      r_retire_done <= 1'b0;
      else if (STALL) r_retire_done <= r_retire_done | w_retire;
      else            r_retire_done <= 1'b0;
    end
  end

  assign Instret = r_instret;
`endif

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register and writeback stage of the RV32I pipeline.
- Captures the MEM-stage result and formats load data (LB/LH/LW/LBU/LHU) from the raw memory word.
- Selects the writeback value and drives the register file write port (WE3/A3/WD3) directly.
- Exports the same value as a forwarding source, and suppresses duplicate writes while the stage is held by a stall.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RESET_PC4, 32'h0000_0004, reset value of the captured PC+4 field.

Ports:
- CLK  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-high reset.
- STALL  in  1  hold WB register contents.
- FLUSH  in  1  squash the captured instruction (load a bubble).
- MEM_Valid  in  1  MEM stage holds a real instruction.
- MEM_RegWrite  in  1  instruction writes rd.
- MEM_Rd  in  5  destination register.
- MEM_ResultSrc  in  2  00 ALU, 01 load, 10 PC+4, 11 reserved.
- MEM_Funct3  in  3  load width/sign.
- MEM_ALUResult  in  32  ALU result / load address.
- MEM_ReadData  in  32  raw aligned data-memory word.
- MEM_PCPlus4  in  32  link value.
- WE3  out  1  register file write enable.
- A3  out  5  register file write address.
- WD3  out  32  register file write data.
- WB_Valid  out  1  WB holds a valid instruction.
- WB_FwdEn  out  1  forwarding of WD3 is legal (equals WE3 without the done term).
- MisalignErr  out  1  captured load is misaligned.

Behaviour:
- **Registered state:** valid, regwrite, rd, resultsrc, funct3, aluresult, readdata, pcplus4, done. All outputs are combinational from registered state only; no input-to-output path.
- **Reset:** all state clears to 0 (pcplus4 = RESET_PC4). Outputs: WE3=0, A3=0, WD3=0, WB_Valid=0, WB_FwdEn=0, MisalignErr=0. Reset asserted mid-operation kills the held instruction; no write occurs in that cycle.
- **Capture priority:** FLUSH > STALL > load.
  - FLUSH: valid<=0, done<=0, other fields unchanged.
  - STALL: all fields hold. done<=1 if WE3 was 1 this cycle.
  - Otherwise: capture all MEM_* fields, done<=0.
- **Latency:** an instruction at MEM on edge N drives WE3 during cycle N..N+1. The write lands on edge N+1.
- **Load formatting:** byte lane = aluresult[1:0].
  - LB/LBU (000/100): select byte [8*lane+7:8*lane], sign- or zero-extend.
  - LH/LHU (001/101): select half aluresult[1]; misaligned if aluresult[0]=1.
  - LW (010): misaligned if aluresult[1:0]!=0.
  - Undefined funct3: result 0, not misaligned.
- **Result select:** 00 aluresult, 01 formatted load, 10 pcplus4, 11 32'h0.
- **MisalignErr** = valid & resultsrc==01 & misaligned.
- **WB_FwdEn** = valid & regwrite & rd!=0 & !MisalignErr.
- **WE3** = WB_FwdEn & !done. Guarantees exactly one write per instruction across any stall length.
- **x0:** rd=0 never asserts WE3. A3/WD3 still reflect the captured values.
- **FLUSH and STALL together:** FLUSH wins.

Optional Feature:
- Macro WB_INSTRET_EN.
- Defined: adds output Instret (64 bits), reset 0. It increments by 1 on each edge where valid & !done & !FLUSH & !MisalignErr (counts retirements, including non-writing instructions). Holds during stall after the first count, using the same done semantics tracked by a separate retire_done bit. Wraps from all-ones to 0.
- Undefined: no port, no counter logic.

Decomposition:
- Package riscv_pkg:
  - ResultSrc encodings (RES_ALU, RES_LOAD, RES_PC4).
  - Load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - XLEN.
- Sub-module load_formatter: purely combinational (funct3, addr[1:0], word -> data, misalign).

Test Plan:
- **Reset then ALU result:** RESET pulse, then capture ResultSrc=00, Rd=5, ALUResult=32'h1234_5678, RegWrite=1 -> next cycle WE3=1, A3=5, WD3=32'h1234_5678.
- **Load formatting:** ReadData=32'h80F1_7F02.
  - LB addr 1 -> WD3=32'h0000_007F.
  - LB addr 2 -> 32'hFFFF_FFF1.
  - LBU addr 3 -> 32'h0000_0080.
  - LH addr 2 -> 32'hFFFF_80F1.
  - LHU addr 0 -> 32'h0000_7F02.
- **Misaligned loads:** LW addr 32'h...02 -> MisalignErr=1, WE3=0. LH addr 1 -> MisalignErr=1.
- **Stall:** capture Rd=7, then STALL for 3 cycles -> WE3=1 in the first cycle only, then 0; WB_FwdEn=1 throughout. Release -> next instruction writes.
- **x0 and JAL link:** x0 write with ALUResult=32'hDEAD_BEEF -> WE3=0. JAL with ResultSrc=10, PCPlus4=32'h0000_0104, Rd=1 -> WD3=32'h0000_0104.
- **Flush priority and async reset:** FLUSH and STALL asserted together -> WB_Valid=0 next cycle. RESET asserted mid-cycle while WE3=1 -> WE3 drops immediately, without waiting for a clock edge.
